// File: rtl/wb_window_gather.sv
// wb_window_gather: pipelined Wishbone gather of a KxK element window
// into a flat register bus, with row-strided addressing and ack watchdog.
module wb_window_gather #(
  parameter int K       = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     stride,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [K*K*DATA_W-1:0] window,
  input  logic [31:0]           data_o,
  input  logic                  stall_o,
  input  logic                  sdram_ack,
  output logic                  stb_i,
  output logic                  cyc_i,
  output logic                  we_i,
  output logic [3:0]            sel_i,
  output logic [ADDR_W-1:0]     addr_i,
  output logic [31:0]           data_i
);

  localparam int N  = K * K;
  localparam int CW = $clog2(N + 1);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int NB = (DATA_W + 7) / 8;
  localparam logic [4:0]    SEL  = (5'd1 << NB) - 5'd1;
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t state_q, state_d;

  logic              mode_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [KW-1:0]     col_q, col_d;
  logic [CW-1:0]     iss_q, ack_q, outst;
  logic [WW-1:0]     wd_q;
  logic [N-1:0][DATA_W-1:0] win_q;

  logic act, accept, ack_v, quiet;
  logic wd_exp, last_col;
  logic unused;

  assign act    = (state_q == S_REQ) ||
                  (state_q == S_WAIT);
  assign outst  = iss_q - ack_q;
  assign stb_i  = (state_q == S_REQ) &&
                  (iss_q < N_C) &&
                  (int'(outst) < MAX_OUT);
  assign cyc_i  = act;
  assign busy   = act;
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ABORT);
  assign we_i   = 1'b0;
  assign data_i = '0;
  assign sel_i  = SEL[3:0];
  assign addr_i = addr_q;
  assign window = win_q;
  assign unused = ^data_o;

  assign accept = stb_i && !stall_o;
  assign ack_v  = sdram_ack && cyc_i &&
                  (ack_q < iss_q);
  assign quiet  = !accept && !ack_v;
  // wd_q is the number of cycles since the last bus progress
  assign wd_exp = act && quiet &&
                  (outst != '0) &&
                  (wd_q >= WW'(TIMEOUT - 1));
  assign last_col = (col_q == KW'(K - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ: begin
        if (wd_exp)
          state_d = S_ABORT;
        else if (accept && iss_q == LAST)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wd_exp)
          state_d = S_ABORT;
        else if (ack_v && ack_q == LAST)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q + ADDR_W'(1);
    row_d  = row_q;
    col_d  = col_q + KW'(1);
    if (last_col) begin
      col_d = '0;
      if (mode_q) begin
        row_d  = row_q + stride_q;
        addr_d = row_q + stride_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      stride_q <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      col_q    <= '0;
      iss_q    <= '0;
      ack_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        mode_q   <= mode;
        stride_q <= stride;
        row_q    <= base_addr;
        addr_q   <= base_addr;
        col_q    <= '0;
        iss_q    <= '0;
        ack_q    <= '0;
        wd_q     <= '0;
      end
      if (accept) begin
        iss_q  <= iss_q + CW'(1);
        addr_q <= addr_d;
        row_q  <= row_d;
        col_q  <= col_d;
      end
      if (ack_v)
        ack_q <= ack_q + CW'(1);
      if (act) begin
        if (!quiet)
          wd_q <= WW'(1);
        else if (outst != '0)
          wd_q <= wd_q + WW'(1);
      end
    end
  end

  // element 0 lands in the most significant slot
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      win_q <= '0;
    else if (ack_v)
      win_q[LAST - ack_q] <= data_o[DATA_W-1:0];
  end

endmodule

// File: tb/tb_wb_window_gather.sv
// tb_wb_window_gather: directed and randomized gathers against a
// behavioural in-order Wishbone slave and an address/window model.
`timescale 1ns/1ps
module tb_wb_window_gather;
  localparam int K  = 3;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam int TO = 255;
  localparam int N  = K * K;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic busy, done, err;
  logic [N*DW-1:0] window;
  logic [31:0] data_o = '0;
  logic stall_o = 1'b0;
  logic sdram_ack = 1'b0;
  logic stb_i, cyc_i, we_i;
  logic [3:0] sel_i;
  logic [AW-1:0] addr_i;
  logic [31:0] data_i;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  logic [N*DW-1:0] exp_win = '0;
  int q_due[$];
  logic [DW-1:0] q_dat[$];

  wb_window_gather #(
    .K(K), .DATA_W(DW), .ADDR_W(AW),
    .MAX_OUT(MO), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .start(start), .mode(mode),
    .base_addr(base_addr), .stride(stride),
    .busy(busy), .done(done), .err(err),
    .window(window),
    .data_o(data_o), .stall_o(stall_o),
    .sdram_ack(sdram_ack),
    .stb_i(stb_i), .cyc_i(cyc_i), .we_i(we_i),
    .sel_i(sel_i), .addr_i(addr_i),
    .data_i(data_i)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1; cyc++;
      start = 1'b0;
      sdram_ack = 1'b0;
      stall_o = 1'b0;
    end
  endtask

  task automatic gather(
    input bit md, input logic [AW-1:0] base,
    input logic [AW-1:0] strd, input int dly,
    input bit acken, input int st_idx,
    input int st_len, input int restart_at,
    input int rst_ack, input bit dat_addr,
    input bit exp_err, input int exp_lat);
    logic [AW-1:0] ea [N];
    logic [DW-1:0] ed [N];
    logic [N*DW-1:0] w;
    int s, acc, acks, st_left, last_evt;
    int done_cnt, done_cyc, err_cyc;
    s = 0; acc = 0; acks = 0; st_left = st_len;
    last_evt = 0; done_cnt = 0;
    done_cyc = -1; err_cyc = -1;
    for (int n = 0; n < N; n++)
      ea[n] = md ? base + strd * AW'(n / K) + AW'(n % K)
                 : base + AW'(n);
    q_due.delete();
    q_dat.delete();
    for (int t = 0; t < 600; t++) begin
      @(posedge CLK); #1; cyc++;
      start = (t == 0) || (t == restart_at);
      if (t == 0) begin
        mode = md; base_addr = base;
        stride = strd; s = cyc;
      end else begin
        mode = 1'($urandom);
        base_addr = $urandom;
        stride = $urandom;
      end
      stall_o = 1'b0;
      if (stb_i && acc == st_idx && st_left > 0) begin
        stall_o = 1'b1;
        st_left--;
      end
      sdram_ack = 1'b0;
      data_o = $urandom;
      if (acken && cyc_i && q_due.size() > 0 &&
          q_due[0] <= cyc) begin
        sdram_ack = 1'b1;
        data_o = {16'($urandom), q_dat.pop_front()};
        void'(q_due.pop_front());
        acks++;
        last_evt = cyc;
        if (acks == rst_ack) begin
          #1 rst_n = 1'b0;
          #1;
          chk("rst_cyc", cyc_i, 1'b0);
          chk("rst_stb", stb_i, 1'b0);
          chk("rst_busy", busy, 1'b0);
          chk("rst_win", window, '0);
          sdram_ack = 1'b0;
          start = 1'b0;
          rst_n = 1'b1;
          exp_win = '0;
          return;
        end
      end
      #1;
      if (stb_i && acc >= N)
        chk("stb_extra", stb_i, 1'b0);
      if (stb_i && acc < N)
        chk($sformatf("addr%0d", acc), addr_i, ea[acc]);
      if (stb_i && !stall_o && acc < N) begin
        ed[acc] = dat_addr ? ea[acc][DW-1:0] : DW'($urandom);
        q_due.push_back(cyc + dly);
        q_dat.push_back(ed[acc]);
        acc++;
        last_evt = cyc;
        chk("outstanding_le_max", (acc - acks) <= MO, 1'b1);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err && err_cyc < 0) err_cyc = cyc;
      if (done_cyc >= 0 || err_cyc >= 0) break;
    end
    chk("end_seen", (done_cyc >= 0) || (err_cyc >= 0), 1'b1);
    if (!exp_err) begin
      for (int n = 0; n < N; n++)
        w[(N-1-n)*DW +: DW] = ed[n];
      chk("done_busy", busy, 1'b0);
      chk("done_cyc_low", cyc_i, 1'b0);
      chk("done_no_err", err, 1'b0);
      chk("window", window, w);
      if (exp_lat > 0)
        chk("latency", done_cyc - s + 1, exp_lat);
      exp_win = w;
    end else begin
      chk("err_delay", err_cyc - last_evt, TO);
      chk("err_cyc_low", cyc_i, 1'b0);
      chk("err_stb_low", stb_i, 1'b0);
      chk("err_busy", busy, 1'b0);
      chk("err_no_done", done_cnt, 0);
      chk("err_window_kept", window, exp_win);
    end
    @(posedge CLK); #1; cyc++;
    start = 1'b0;
    stall_o = 1'b0;
    sdram_ack = 1'b1;
    data_o = $urandom;
    #1;
    chk("pulse_end", {done, err}, 2'b00);
    chk("idle_cyc", cyc_i, 1'b0);
    @(posedge CLK); #1; cyc++;
    sdram_ack = 1'b0;
    #1;
    chk("stray_ack", window, exp_win);
  endtask

  initial begin
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_err0", err, 1'b0);
    chk("rst_stb0", stb_i, 1'b0);
    chk("rst_cyc0", cyc_i, 1'b0);
    chk("rst_we0", we_i, 1'b0);
    chk("rst_addr0", addr_i, '0);
    chk("rst_win0", window, '0);
    chk("sel", sel_i, 4'b0011);
    chk("data_i", data_i, '0);
    rst_n = 1'b1;
    idle(2);

    gather(1'b0, 32'h10, 32'h0, 1, 1'b1, -1, 0,
           -1, -1, 1'b1, 1'b0, N + 3);
    chk("t1_window", window,
        144'h0010_0011_0012_0013_0014_0015_0016_0017_0018);

    gather(1'b1, 32'h100, 32'd28, 1, 1'b1, -1, 0,
           -1, -1, 1'b1, 1'b0, 0);

    gather(1'b0, $urandom, 32'h0, 5, 1'b1, 1, 3,
           -1, -1, 1'b0, 1'b0, 0);

    gather(1'b0, 32'h1000, 32'h0, 1, 1'b0, -1, 0,
           -1, -1, 1'b0, 1'b1, 0);

    gather(1'b1, 32'h2000, 32'd7, 2, 1'b1, -1, 0,
           -1, -1, 1'b0, 1'b0, 0);

    gather(1'b0, 32'hFFFF_FFFE, 32'h0, 1, 1'b1, -1, 0,
           3, -1, 1'b1, 1'b0, N + 3);

    gather(1'b1, 32'h300, 32'd40, 1, 1'b1, -1, 0,
           -1, 4, 1'b0, 1'b0, 0);

    gather(1'b0, 32'h400, 32'h0, 1, 1'b1, -1, 0,
           -1, -1, 1'b0, 1'b0, N + 3);

    for (int i = 0; i < 8; i++)
      gather(1'($urandom), $urandom,
             32'($urandom_range(0, 64)),
             $urandom_range(1, 6), 1'b1,
             $urandom_range(0, N - 1),
             $urandom_range(0, 4),
             $urandom_range(1, 12), -1,
             1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
